mac2phy_os_detector: RTL
========================

// Module: mac2phy_os_detector
// PURPOSE
//  Receive-side ordered-set decoder for the MAC->PHY symbol stream (txdata/txdatak/txvalid).
//  Aligns on COM and classifies SKP (COM+3xSKP), TS1 and TS2 (COM + bytes1-5 + 10xID).
//  Exports the captured TS bytes 1-5, packed [7:0]=byte1 .. [39:32]=byte5, plus a
//  consecutive-identical-TS count for the LTSSM. Peer of the PHY->MAC ordered-set driver.
// PARAMETERS
//  CNT_W     4   width of ts_consec_cnt; saturates at 2**CNT_W-1
//  SKP_LEN   4   SKP ordered-set length in symbols (COM + SKP_LEN-1 SKP)
// PORTS
//  clk             in   1   symbol clock
//  rst             in   1   asynchronous, active-high reset
//  en_n            in   1   active-low enable; high forces FSM to IDLE
//  txdata          in   8   symbol from MAC
//  txdatak         in   1   1 = txdata is a K symbol
//  txvalid         in   1   symbol qualifier; low = no symbol this cycle (stall)
//  skp_det         out  1   1-cycle pulse: complete SKP set received
//  ts1_det         out  1   1-cycle pulse: complete TS1 received
//  ts2_det         out  1   1-cycle pulse: complete TS2 received
//  ts_bytes1thru5  out  40  bytes 1-5 of the last good TS1/TS2
//  ts_consec_cnt   out  CNT_W  count of back-to-back identical TSs (same type, same bytes1-5)
//  os_err          out  1   1-cycle pulse: malformed or truncated ordered set
//  in_os           out  1   1 while FSM is not IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, byte counter 0, stored header 0.
//  - Symbols are consumed only when txvalid=1 and en_n=0. txvalid=0 holds all state.
//  - Symbol values: COM=K 8'hBC, SKP=K 8'h1C, TS1ID=D 8'h4A, TS2ID=D 8'h45.
//  - FSM:
//    - IDLE: K COM -> HDR0; any other symbol is ignored (no error).
//    - HDR0 (byte1):
//      - K SKP -> SKP_BODY (cnt=2).
//      - Any non-COM symbol -> TS_HDR; the symbol is stored as byte1 (PAD K-codes allowed).
//    - SKP_BODY: each K SKP increments cnt. At cnt==SKP_LEN-1 the set completes:
//      skp_det pulses and the FSM returns to IDLE.
//    - TS_HDR: bytes 2-5 stored unconditionally, then -> TS_ID.
//    - TS_ID:
//      - byte6 must be D TS1ID or D TS2ID; that value is latched as the expected ID.
//      - bytes 7-15 must be D and equal to the expected ID.
//      - byte15 OK: ts1_det/ts2_det pulses, ts_bytes1thru5 updates, FSM -> IDLE.
//  - Latency: det pulses and ts_bytes1thru5 update in the cycle after the last symbol is sampled.
//  - Mismatch inside a set:
//    - os_err pulses and the FSM returns to IDLE.
//    - If the offending symbol is K COM, os_err still pulses and the FSM goes to HDR0
//      (realign); that COM is not lost.
//  - ts_consec_cnt, updated together with a det pulse:
//    - Same type and same bytes1-5 as the previous good TS: +1, saturating.
//    - Otherwise: 1.
//    - SKP sets leave the count unchanged.
//    - os_err clears it to 0.
//  - en_n rising mid-set: FSM -> IDLE, no os_err, ts_consec_cnt cleared; ts_bytes1thru5 held.
//  - Async reset mid-set: immediate return to reset values; no pulse on release.
//  - Only one of skp_det/ts1_det/ts2_det/os_err is high in a cycle, except os_err, which
//    may not coincide with a det pulse since only one set ends per symbol.
// STRUCTURE
//  - ozdefs.sv: COM/SKP/TS1ID/TS2ID macros (existing); add typedef enum os_det_state_t
//    {IDLE,HDR0,SKP_BODY,TS_HDR,TS_ID} and typedef enum os_kind_t {OS_NONE,OS_SKP,OS_TS1,OS_TS2}.
//  - Sub-module os_consec_tracker: holds the previous kind + 40-bit header and the
//    saturating counter; inputs are a det strobe, kind, header and clear.
//  - The decoder FSM and byte counter (4-bit, 0..15) live in this module.
// TESTING
//  1. Reset, then COM,1C,1C,1C with txvalid=1 -> skp_det=1 one cycle after last SKP;
//     ts_consec_cnt=0; os_err=0.
//  2. TS1 with bytes1-5=F7,F7,0F,02,00 -> ts1_det pulse; ts_bytes1thru5=40'h00020FF7F7;
//     cnt=1. Repeat 8x back-to-back -> cnt=8.
//  3. TS1 x3 then TS2 with same header -> ts2_det; cnt=1. Insert a SKP between two
//     identical TS2 -> cnt=2.
//  4. TS1 with byte10=45 -> os_err pulse, no ts1_det, cnt=0.
//     COM at byte9 -> os_err, then a following full TS1 is detected from that COM.
//  5. txvalid=0 for 3 cycles after byte7 of TS2 -> ts2_det only after byte15 is sampled.
//     en_n=1 at byte4 -> in_os=0 next cycle, no os_err.
//  6. Assert rst mid-TS1 at byte12 -> outputs 0 immediately; a fresh TS1 after release
//     gives cnt=1.

Source files
------------

// File: rtl/mac2phy_os_detector_pkg.sv
// rtl/mac2phy_os_detector_pkg.sv - symbol codes and enums for the ordered-set detector
// Purpose: shared K/D symbol values, decoder state encoding and ordered-set kinds.
// Ports: none (package).
package mac2phy_os_detector_pkg;

    localparam logic [7:0] SYM_COM   = 8'hBC;   // K
    localparam logic [7:0] SYM_SKP   = 8'h1C;   // K
    localparam logic [7:0] SYM_TS1ID = 8'h4A;   // D
    localparam logic [7:0] SYM_TS2ID = 8'h45;   // D

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        SKP_BODY,
        TS_HDR,
        TS_ID
    } os_det_state_t;

    typedef enum logic [1:0] {
        OS_NONE,
        OS_SKP,
        OS_TS1,
        OS_TS2
    } os_kind_t;

endpackage

// File: rtl/mac2phy_os_detector_consec.sv
// rtl/mac2phy_os_detector_consec.sv - consecutive identical training-set counter
// Purpose: remembers the kind and bytes 1-5 of the last good TS and counts
//          back-to-back repeats, saturating at 2**CNT_W-1.
// Ports: clk, rst (async, active-high); det strobe with kind/hdr of a completed
//        TS; clr zeroes the count; count is the saturating repeat count.
module mac2phy_os_detector_consec
    import mac2phy_os_detector_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det,
    input  os_kind_t         kind,
    input  logic [39:0]      hdr,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    os_kind_t    prev_kind;
    logic [39:0] prev_hdr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_kind <= OS_NONE;
            prev_hdr  <= '0;
            count     <= '0;
        end else if (clr) begin
            // Forget the previous TS so the next good one restarts at 1.
            prev_kind <= OS_NONE;
            count     <= '0;
        end else if (det) begin
            prev_kind <= kind;
            prev_hdr  <= hdr;
            if (kind == prev_kind && hdr == prev_hdr) begin
                if (count != CNT_MAX) begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mac2phy_os_detector.sv
// rtl/mac2phy_os_detector.sv - MAC->PHY ordered-set decoder (SKP, TS1, TS2)
// Purpose: aligns on COM, classifies SKP/TS1/TS2, captures TS bytes 1-5 and
//          reports a consecutive-identical-TS count.
// Ports: clk, rst (async, active-high), en_n (active-low enable);
//        txdata/txdatak/txvalid symbol input;
//        skp_det/ts1_det/ts2_det/os_err one-cycle pulses; ts_bytes1thru5
//        last good header ([7:0]=byte1); ts_consec_cnt; in_os (FSM not IDLE).
module mac2phy_os_detector #(
    parameter int CNT_W   = 4,
    parameter int SKP_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_n,
    input  logic [7:0]       txdata,
    input  logic             txdatak,
    input  logic             txvalid,
    output logic             skp_det,
    output logic             ts1_det,
    output logic             ts2_det,
    output logic [39:0]      ts_bytes1thru5,
    output logic [CNT_W-1:0] ts_consec_cnt,
    output logic             os_err,
    output logic             in_os
);

    import mac2phy_os_detector_pkg::*;

    localparam logic [3:0] SKP_LAST = 4'(SKP_LEN - 1);

    os_det_state_t state, state_nxt;
    logic [3:0]    idx;      // symbol index within the current set, COM = 0
    logic [39:0]   hdr;
    logic [7:0]    exp_id;
    os_kind_t      ts_kind;

    logic take, is_com, is_skp, id_match;
    logic skp_done, ts_done, err_hit;

    assign take    = txvalid & ~en_n;
    assign is_com  = txdatak && (txdata == SYM_COM);
    assign is_skp  = txdatak && (txdata == SYM_SKP);
    // Byte 6 selects the ID; bytes 7-15 must repeat it.
    assign id_match = !txdatak && ((idx == 4'd6) ? (txdata == SYM_TS1ID || txdata == SYM_TS2ID)
                                                 : (txdata == exp_id));
    assign ts_kind = (exp_id == SYM_TS1ID) ? OS_TS1 : OS_TS2;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a bad COM realigns to HDR0 instead of dropping to IDLE.
    always_comb begin
        state_nxt = state;
        if (en_n) begin
            state_nxt = IDLE;
        end else if (txvalid) begin
            case (state)
                IDLE:     if (is_com) state_nxt = HDR0;
                HDR0:     if (is_skp)      state_nxt = SKP_BODY;
                          else if (is_com) state_nxt = HDR0;
                          else             state_nxt = TS_HDR;
                SKP_BODY: if (is_skp)      state_nxt = (idx == SKP_LAST) ? IDLE : SKP_BODY;
                          else if (is_com) state_nxt = HDR0;
                          else             state_nxt = IDLE;
                TS_HDR:   if (idx == 4'd5) state_nxt = TS_ID;
                TS_ID:    if (id_match)    state_nxt = (idx == 4'd15) ? IDLE : TS_ID;
                          else if (is_com) state_nxt = HDR0;
                          else             state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // Output decode: which set (if any) ends on this symbol.
    always_comb begin
        skp_done = 1'b0;
        ts_done  = 1'b0;
        err_hit  = 1'b0;
        if (take) begin
            case (state)
                HDR0:     err_hit = is_com;
                SKP_BODY: if (is_skp) skp_done = (idx == SKP_LAST);
                          else        err_hit  = 1'b1;
                TS_ID:    if (id_match) ts_done = (idx == 4'd15);
                          else          err_hit = 1'b1;
                default:  ;
            endcase
        end
    end

    assign in_os = (state != IDLE);

    // Datapath: symbol index, header capture, ID latch, registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx            <= '0;
            hdr            <= '0;
            exp_id         <= '0;
            skp_det        <= 1'b0;
            ts1_det        <= 1'b0;
            ts2_det        <= 1'b0;
            os_err         <= 1'b0;
            ts_bytes1thru5 <= '0;
        end else begin
            skp_det <= skp_done;
            ts1_det <= ts_done && (ts_kind == OS_TS1);
            ts2_det <= ts_done && (ts_kind == OS_TS2);
            os_err  <= err_hit;
            if (ts_done) begin
                ts_bytes1thru5 <= hdr;
            end
            if (en_n) begin
                idx <= '0;
            end else if (txvalid) begin
                if (state_nxt == IDLE)      idx <= '0;
                else if (state_nxt == HDR0) idx <= 4'd1;
                else                        idx <= idx + 1'b1;

                if (state == HDR0 && !is_skp && !is_com) begin
                    hdr[7:0] <= txdata;
                end
                if (state == TS_HDR) begin
                    case (idx)
                        4'd2:    hdr[15:8]  <= txdata;
                        4'd3:    hdr[23:16] <= txdata;
                        4'd4:    hdr[31:24] <= txdata;
                        4'd5:    hdr[39:32] <= txdata;
                        default: ;
                    endcase
                end
                if (state == TS_ID && idx == 4'd6) begin
                    exp_id <= txdata;
                end
            end
        end
    end

    mac2phy_os_detector_consec #(
        .CNT_W (CNT_W)
    ) u_consec (
        .clk   (clk),
        .rst   (rst),
        .det   (ts_done),
        .kind  (ts_kind),
        .hdr   (hdr),
        .clr   (err_hit | (en_n & in_os)),
        .count (ts_consec_cnt)
    );

endmodule
